subleq_controller: RTL and testbench

//   Sequencing FSM for the SUBLEQ datapath: drives the 4-bit state code and all load/memory/PC enables,

---
 rtl/subleq_pkg.sv | 32 +++
 rtl/subleq_controller.sv | 152 +++++++++++++++
 tb/tb_subleq_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/subleq_pkg.sv
// rtl/subleq_pkg.sv - state codes for the SUBLEQ sequencer
//
// Purpose: 4-bit state encoding shared by subleq_controller, the datapath
// and pc_incre. Codes 0..14 are always present. Code 15 (ST_PAUSE) exists
// only when SUBLEQ_STEP_EN is defined.
package subleq_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH_A     = 4'd0,
    ST_LOAD_A      = 4'd1,
    ST_FETCH_B     = 4'd2,
    ST_LOAD_B      = 4'd3,
    ST_FETCH_C     = 4'd4,
    ST_LOAD_C      = 4'd5,
    ST_FETCH_MEM_A = 4'd6,
    ST_LOAD_MEM_A  = 4'd7,
    ST_FETCH_MEM_B = 4'd8,
    ST_LOAD_MEM_B  = 4'd9,
    ST_EXECUTE     = 4'd10,
    ST_WRITEBACK   = 4'd11,
    ST_UPDATE_PC   = 4'd12,
    ST_IDLE        = 4'd13,
    ST_HALT        = 4'd14
`ifdef SUBLEQ_STEP_EN
    ,
    ST_PAUSE       = 4'd15
`endif
  } state_e;

endpackage

// File: rtl/subleq_controller.sv
// rtl/subleq_controller.sv - SUBLEQ sequencing FSM with start/halt and retired-instruction counter
//
// Purpose: issues every datapath control for one SUBLEQ instruction:
//   fetch/load a, b and c, then mem[a] and mem[b], execute, write back, and update the PC.
// Optional feature: define SUBLEQ_STEP_EN to add the step input and the PAUSE state.
//   In that build each non-halting instruction parks in PAUSE until step is pulsed.
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               leaves IDLE/HALT and clears icnt
//   mem_ready           memory handshake; only looked at in FETCH_* and WRITEBACK
//   mem_data            c operand snoop, used for halt detection
//   zero, negative      ALU flags after the subtract
//   step                (SUBLEQ_STEP_EN only) releases PAUSE
//   state               current state code to the datapath
//   *_ld, mem_read, mem_write, pc_ld, branch_take   Moore decodes of state
//   busy, halted        status outputs
//   icnt                instructions retired since the last start
module subleq_controller
  import subleq_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] HALT_ADDR = '1,
  parameter int                ICNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               zero,
  input  logic               negative,
`ifdef SUBLEQ_STEP_EN
  input  logic               step,
`endif
  output logic [STATE_W-1:0] state,
  output logic               a_ld,
  output logic               b_ld,
  output logic               c_ld,
  output logic               mem_a_ld,
  output logic               mem_b_ld,
  output logic               result_ld,
  output logic               mem_read,
  output logic               mem_write,
  output logic               pc_ld,
  output logic               branch_take,
  output logic               busy,
  output logic               halted,
  output logic [ICNT_W-1:0]  icnt
);

  state_e              state_q, state_d;
  logic                take_q, take_d;
  logic                halt_pend_q, halt_pend_d;
  logic [ICNT_W-1:0]   icnt_q, icnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      take_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      icnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      take_q      <= take_d;
      halt_pend_q <= halt_pend_d;
      icnt_q      <= icnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    take_d      = take_q;
    halt_pend_d = halt_pend_q;
    icnt_d      = icnt_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH_A;
          icnt_d  = '0;
        end
      end
      ST_FETCH_A:     if (mem_ready) state_d = ST_LOAD_A;
      ST_LOAD_A:      state_d = ST_FETCH_B;
      ST_FETCH_B:     if (mem_ready) state_d = ST_LOAD_B;
      ST_LOAD_B:      state_d = ST_FETCH_C;
      ST_FETCH_C:     if (mem_ready) state_d = ST_LOAD_C;
      ST_LOAD_C: begin
        state_d     = ST_FETCH_MEM_A;
        // A branch target equal to HALT_ADDR marks this as the final instruction.
        halt_pend_d = (mem_data == HALT_ADDR);
      end
      ST_FETCH_MEM_A: if (mem_ready) state_d = ST_LOAD_MEM_A;
      ST_LOAD_MEM_A:  state_d = ST_FETCH_MEM_B;
      ST_FETCH_MEM_B: if (mem_ready) state_d = ST_LOAD_MEM_B;
      ST_LOAD_MEM_B:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
        take_d  = zero | negative;
      end
      ST_WRITEBACK:   if (mem_ready) state_d = ST_UPDATE_PC;
      ST_UPDATE_PC: begin
        icnt_d = icnt_q + {{(ICNT_W-1){1'b0}}, 1'b1};
        // The PC is still loaded on the halting instruction so it reads HALT_ADDR afterwards.
        if (take_q && halt_pend_q) begin
          state_d = ST_HALT;
        end else begin
`ifdef SUBLEQ_STEP_EN
          state_d = ST_PAUSE;
`else
          state_d = ST_FETCH_A;
`endif
        end
      end
`ifdef SUBLEQ_STEP_EN
      ST_PAUSE:       if (step) state_d = ST_FETCH_A;
`endif
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_ld        = 1'b0;
    b_ld        = 1'b0;
    c_ld        = 1'b0;
    mem_a_ld    = 1'b0;
    mem_b_ld    = 1'b0;
    result_ld   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_ld       = 1'b0;
    branch_take = 1'b0;
    case (state_q)
      ST_FETCH_A, ST_FETCH_B, ST_FETCH_C,
      ST_FETCH_MEM_A, ST_FETCH_MEM_B: mem_read = 1'b1;
      ST_LOAD_A:     begin mem_read = 1'b1; a_ld     = 1'b1; end
      ST_LOAD_B:     begin mem_read = 1'b1; b_ld     = 1'b1; end
      ST_LOAD_C:     begin mem_read = 1'b1; c_ld     = 1'b1; end
      ST_LOAD_MEM_A: begin mem_read = 1'b1; mem_a_ld = 1'b1; end
      ST_LOAD_MEM_B: begin mem_read = 1'b1; mem_b_ld = 1'b1; end
      ST_EXECUTE:    result_ld = 1'b1;
      ST_WRITEBACK:  mem_write = 1'b1;
      ST_UPDATE_PC:  begin pc_ld = 1'b1; branch_take = take_q; end
      default:       ;
    endcase
  end

  assign state  = state_q;
  assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted = (state_q == ST_HALT);
  assign icnt   = icnt_q;

endmodule

// File: tb/tb_subleq_controller.sv
// tb/tb_subleq_controller.sv - directed bench for subleq_controller
module tb_subleq_controller;

  logic        clk = 1'b0;
  logic        rst_n, start, mem_ready, zero, negative;
  logic [63:0] mem_data;
`ifdef SUBLEQ_STEP_EN
  logic        step;
  localparam logic [3:0] AFTER = 4'd15;
`else
  localparam logic [3:0] AFTER = 4'd0;
`endif
  logic [3:0]  state;
  logic        a_ld, b_ld, c_ld, mem_a_ld, mem_b_ld, result_ld;
  logic        mem_read, mem_write, pc_ld, branch_take, busy, halted;
  logic [31:0] icnt;

  localparam logic [63:0] HALT = {64{1'b1}};

  int n_cmp = 0;
  int n_bad = 0;

  subleq_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready),
    .mem_data(mem_data), .zero(zero), .negative(negative),
`ifdef SUBLEQ_STEP_EN
    .step(step),
`endif
    .state(state), .a_ld(a_ld), .b_ld(b_ld), .c_ld(c_ld),
    .mem_a_ld(mem_a_ld), .mem_b_ld(mem_b_ld), .result_ld(result_ld),
    .mem_read(mem_read), .mem_write(mem_write), .pc_ld(pc_ld),
    .branch_take(branch_take), .busy(busy), .halted(halted), .icnt(icnt)
  );

  always #5 clk = ~clk;

  // {a,b,c,mem_a,mem_b,result,mem_read,mem_write,pc_ld,branch_take,busy,halted}
  typedef struct packed {
    logic [3:0]  st;
    logic [11:0] ctl;
  } vec_t;
  vec_t walk [13];

  function automatic logic [11:0] ctl_now();
    return {a_ld, b_ld, c_ld, mem_a_ld, mem_b_ld, result_ld,
            mem_read, mem_write, pc_ld, branch_take, busy, halted};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_instr();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input string name);
    int k = 0;
    while (k < 60 && state !== s) begin
      tick();
      k++;
    end
    chk(name, state, s);
  endtask

  task automatic resume();
`ifdef SUBLEQ_STEP_EN
    chk("resume_pause", state, 4'd15);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("resume_fetch", state, 4'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    walk[0]  = '{4'd0,  12'b000000_1000_10};
    walk[1]  = '{4'd1,  12'b100000_1000_10};
    walk[2]  = '{4'd2,  12'b000000_1000_10};
    walk[3]  = '{4'd3,  12'b010000_1000_10};
    walk[4]  = '{4'd4,  12'b000000_1000_10};
    walk[5]  = '{4'd5,  12'b001000_1000_10};
    walk[6]  = '{4'd6,  12'b000000_1000_10};
    walk[7]  = '{4'd7,  12'b000100_1000_10};
    walk[8]  = '{4'd8,  12'b000000_1000_10};
    walk[9]  = '{4'd9,  12'b000010_1000_10};
    walk[10] = '{4'd10, 12'b000001_0000_10};
    walk[11] = '{4'd11, 12'b000000_0100_10};
    walk[12] = '{4'd12, 12'b000000_0010_10};

    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
    mem_data = 64'd0; zero = 1'b0; negative = 1'b0;
`ifdef SUBLEQ_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", state, 4'd13);
    chk("reset_ctl", ctl_now(), 12'b0);
    chk("reset_icnt", icnt, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", state, 4'd13);

    // Full instruction, mem_ready tied high, difference positive (no branch).
    mem_ready = 1'b1; mem_data = 64'd100; zero = 1'b0; negative = 1'b0;
    begin_instr();
    for (int i = 0; i < 13; i++) begin
      start = (i == 4);
      chk($sformatf("walk%0d_state", i), state, walk[i].st);
      chk($sformatf("walk%0d_ctl", i), ctl_now(), walk[i].ctl);
      tick();
    end
    start = 1'b0;
    chk("walk_after", state, AFTER);
    chk("walk_icnt", icnt, 32'd1);
`ifdef SUBLEQ_STEP_EN
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pause%0d_state", i), state, 4'd15);
      chk($sformatf("pause%0d_ctl", i), ctl_now(), 12'b000000_0000_10);
      tick();
    end
    chk("pause_icnt", icnt, 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_fetch", state, 4'd0);
    repeat (13) tick();
    chk("step_pause_again", state, 4'd15);
    chk("step_icnt", icnt, 32'd2);
    resume();
`endif

    // Memory stall in FETCH_B.
    chk("t3_start", state, 4'd0);
    tick();
    tick();
    chk("t3_fetch_b", state, 4'd2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_stall%0d_state", i), state, 4'd2);
      chk($sformatf("t3_stall%0d_rd", i), mem_read, 1'b1);
      chk($sformatf("t3_stall%0d_bld", i), b_ld, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    chk("t3_last_state", state, 4'd2);
    chk("t3_last_rd", mem_read, 1'b1);
    tick();
    chk("t3_load_b", state, 4'd3);
    chk("t3_bld", b_ld, 1'b1);
    tick();
    chk("t3_fetch_c", state, 4'd4);
    chk("t3_bld_once", b_ld, 1'b0);
    wait_state(4'd12, "t3_upd");
    tick();
    chk("t3_after", state, AFTER);
    resume();

    // Equal operands, c = HALT_ADDR: zero flag, branch taken, halt.
    mem_data = HALT; zero = 1'b1; negative = 1'b0;
    wait_state(4'd12, "t4_upd");
    chk("t4_take", branch_take, 1'b1);
    chk("t4_pcld", pc_ld, 1'b1);
    tick();
    chk("t4_halt", state, 4'd14);
    chk("t4_ctl", ctl_now(), 12'b000000_0000_01);
    tick();
    chk("t4_halt_hold", state, 4'd14);
    begin_instr();
    chk("t4_restart", state, 4'd0);
    chk("t4_icnt_clr", icnt, 32'd0);

    // Negative result, c = HALT_ADDR+1: branch taken but no halt.
    mem_data = HALT + 64'd1; zero = 1'b0; negative = 1'b1;
    wait_state(4'd12, "t5_upd");
    chk("t5_take", branch_take, 1'b1);
    tick();
    chk("t5_after", state, AFTER);
    chk("t5_halted", halted, 1'b0);
    chk("t5_icnt", icnt, 32'd1);
    resume();

    // Asynchronous reset during a stalled WRITEBACK.
    negative = 1'b0;
    wait_state(4'd11, "t1_wb");
    mem_ready = 1'b0;
    tick();
    chk("t1_wb_hold", state, 4'd11);
    chk("t1_wr", mem_write, 1'b1);
    chk("t1_icnt_pre", icnt, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_state", state, 4'd13);
    chk("t1_rst_wr", mem_write, 1'b0);
    chk("t1_rst_icnt", icnt, 32'd0);
    mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_idle_after", state, 4'd13);
    chk("t1_no_write", mem_write, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
